// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution driving the fetch redirect, and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [31:0]     InstrE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      Funct3M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [XLEN-1:0] LSB_CLEAR = ~{{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
    logic [4:0]      rd_q,         rd_d;
    logic            reg_write_q,  reg_write_d;
    logic            mem_write_q,  mem_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic [2:0]      funct3_q,     funct3_d;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [2:0]      funct3;
    logic            br_taken;
    logic [XLEN-1:0] jalr_sum;

    assign funct3 = InstrE[14:12];
    assign Rs1E   = InstrE[19:15];
    assign Rs2E   = InstrE[24:20];

    // Encoding 10 feeds back the EX/MEM result latched at the previous edge.
    always_comb begin
        fwd_a = RD1_E;
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = alu_result_q;
            default: fwd_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : fwd_b;

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD: alu_result = fwd_a + src_b;
            ALU_SUB: alu_result = fwd_a - src_b;
            ALU_AND: alu_result = fwd_a & src_b;
            ALU_OR:  alu_result = fwd_a | src_b;
            ALU_XOR: alu_result = fwd_a ^ src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
            ALU_SLL: alu_result = fwd_a << src_b[4:0];
            ALU_SRL: alu_result = fwd_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    // Branch compare always uses the register operands, never the immediate.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            BR_EQ:   br_taken = (fwd_a == fwd_b);
            BR_NE:   br_taken = (fwd_a != fwd_b);
            BR_LT:   br_taken = ($signed(fwd_a) < $signed(fwd_b));
            BR_GE:   br_taken = ($signed(fwd_a) >= $signed(fwd_b));
            BR_LTU:  br_taken = (fwd_a < fwd_b);
            BR_GEU:  br_taken = (fwd_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

    assign jalr_sum  = fwd_a + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & br_taken);
    assign PCTargetE = jalrE ? (jalr_sum & LSB_CLEAR) : (PCE + ImmExtE);

    // A flush turns the slot into a bubble by killing its side effects only.
    always_comb begin
        alu_result_d = alu_result;
        write_data_d = fwd_b;
        pc_plus4_d   = PCPlus4E;
        funct3_d     = funct3;
        rd_d         = FlushM ? 5'd0 : RdE;
        reg_write_d  = FlushM ? 1'b0 : RegWriteE;
        mem_write_d  = FlushM ? 1'b0 : MemWriteE;
        result_src_d = FlushM ? 2'b00 : ResultSrcE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign Funct3M    = funct3_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized bench for execute_cycle: a behavioural model predicts redirect
// outputs every cycle and the EX/MEM contents after every edge.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE, FlushM;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  Rs1E, Rs2E, RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;

    int checks = 0;
    int errors = 0;

    // model of the EX/MEM register contents
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [2:0]  m_f3;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd,
                                         input logic [31:0] resw, input logic [31:0] prev);
        if (sel == 2'd1) return resw;
        if (sel == 2'd2) return prev;
        return rd;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 32'(a + b);
            3'd1: return 32'(a + ~b + 32'd1);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'(longint'(a) * (longint'(1) << sh));
            default: return 32'(longint'(a) / (longint'(1) << sh));
        endcase
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        m_rw = 0; m_mw = 0; m_rs = 0; m_f3 = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ALUResultM"}, ALUResultM, m_alu);
        chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
        chk({tag, ".PCPlus4M"}, PCPlus4M, m_pc4);
        chk({tag, ".RdM"}, 32'(RdM), 32'(m_rd));
        chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(m_rw));
        chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'(m_mw));
        chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(m_rs));
        chk({tag, ".Funct3M"}, 32'(Funct3M), 32'(m_f3));
    endtask

    // Checks redirect outputs now, then the EX/MEM contents after the next edge.
    task automatic step(input string tag);
        logic [31:0] fa, fb, sb, tgt;
        logic        pcs;
        logic [2:0]  f3;
        #1;
        f3  = InstrE[14:12];
        fa  = pick(ForwardAE, RD1_E, ResultW, m_alu);
        fb  = pick(ForwardBE, RD2_E, ResultW, m_alu);
        sb  = ALUSrcE ? ImmExtE : fb;
        pcs = JumpE || (BranchE && taken_ref(f3, fa, fb));
        tgt = jalrE ? (32'(fa + ImmExtE) & 32'hFFFF_FFFE) : 32'(PCE + ImmExtE);
        chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(pcs));
        chk({tag, ".PCTargetE"}, PCTargetE, tgt);
        chk({tag, ".Rs1E"}, 32'(Rs1E), 32'(InstrE[19:15]));
        chk({tag, ".Rs2E"}, 32'(Rs2E), 32'(InstrE[24:20]));
        @(posedge clk);
        m_alu = alu_ref(ALUControlE, fa, sb);
        m_wd  = fb;
        m_pc4 = PCPlus4E;
        m_f3  = f3;
        m_rd  = FlushM ? 5'd0 : RdE;
        m_rw  = FlushM ? 1'b0 : RegWriteE;
        m_mw  = FlushM ? 1'b0 : MemWriteE;
        m_rs  = FlushM ? 2'd0 : ResultSrcE;
        #1;
        check_regs(tag);
    endtask

    task automatic clear_inputs();
        RD1_E = 0; RD2_E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; InstrE = 0;
        ResultW = 0; RdE = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; jalrE = 0;
        BranchE = 0; ALUSrcE = 0; FlushM = 0; ALUControlE = 0; ResultSrcE = 0;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        RD1_E = rand_word(); RD2_E = rand_word(); ImmExtE = rand_word();
        ResultW = rand_word();
        if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
        PCE = $urandom & 32'hFFFF_FFFC; PCPlus4E = 32'(PCE + 4);
        InstrE = $urandom; RdE = 5'($urandom);
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
        JumpE = ($urandom_range(0, 5) == 0); jalrE = 1'($urandom);
        BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
        FlushM = ($urandom_range(0, 4) == 0);
        ALUControlE = 3'($urandom); ResultSrcE = 2'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    endtask

    initial begin
        clear_inputs();
        model_clear();
        rst = 1'b1;
        #12;
        check_regs("por");
        @(negedge clk);
        rst = 1'b0;

        // add wraps to zero
        RD1_E = 32'hFFFF_FFFF; RD2_E = 32'h1; ALUControlE = 3'b000;
        step("add_wrap");
        chk("add_wrap.lit", ALUResultM, 32'h0);

        // signed slt: 0x80000000 < 1
        RD1_E = 32'h8000_0000; ALUControlE = 3'b101;
        step("slt");
        chk("slt.lit", ALUResultM, 32'h1);

        // forwarding: produce 0x10, then sub it against ResultW
        RD1_E = 32'h8; RD2_E = 32'h8; ALUControlE = 3'b000;
        step("fwd_prep");
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h5; ALUControlE = 3'b001;
        RD1_E = 32'hDEAD_0000; RD2_E = 32'h1234_5678;
        step("fwd");
        chk("fwd.alu.lit", ALUResultM, 32'hB);
        chk("fwd.wd.lit", WriteDataM, 32'h5);

        // unsigned vs signed branch compare
        clear_inputs();
        BranchE = 1; InstrE = 32'h0000_6000; RD1_E = 32'h1; RD2_E = 32'hFFFF_FFFF;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        chk("bltu.pcsrc.lit", 32'(PCSrcE), 32'h1);
        chk("bltu.tgt.lit", PCTargetE, 32'hF8);
        step("bltu");
        InstrE = 32'h0000_4000;
        #1;
        chk("blt.pcsrc.lit", 32'(PCSrcE), 32'h0);
        step("blt");

        // jalr clears bit 0 of the target
        clear_inputs();
        JumpE = 1; jalrE = 1; RD1_E = 32'h203; ImmExtE = 32'h4;
        PCPlus4E = 32'h104; RegWriteE = 1; RdE = 5'd1;
        #1;
        chk("jalr.pcsrc.lit", 32'(PCSrcE), 32'h1);
        chk("jalr.tgt.lit", PCTargetE, 32'h206);
        step("jalr");
        chk("jalr.pc4.lit", PCPlus4M, 32'h104);
        chk("jalr.rw.lit", 32'(RegWriteM), 32'h1);

        // flush kills side effects, next cycle captures normally
        clear_inputs();
        MemWriteE = 1; RegWriteE = 1; RdE = 5'd7; ResultSrcE = 2'b01; FlushM = 1;
        RD2_E = 32'hCAFE_F00D; InstrE = 32'h0000_2000;
        step("flush");
        chk("flush.mw.lit", 32'(MemWriteM), 32'h0);
        chk("flush.rd.lit", 32'(RdM), 32'h0);
        chk("flush.wd.lit", WriteDataM, 32'hCAFE_F00D);
        FlushM = 0;
        step("post_flush");
        chk("post_flush.mw.lit", 32'(MemWriteM), 32'h1);
        chk("post_flush.rd.lit", 32'(RdM), 32'h7);

        // flush does not suppress a taken branch redirect
        clear_inputs();
        BranchE = 1; FlushM = 1; RD1_E = 32'h9; RD2_E = 32'h9;
        step("flush_branch");

        // asynchronous reset mid-cycle with nonzero inputs
        randomize_inputs();
        FlushM = 0; RegWriteE = 1; PCPlus4E = 32'h44;
        step("pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check_regs("async_rst");
        chk("async_rst.pc4.lit", PCPlus4M, 32'h0);
        @(posedge clk);
        #1;
        check_regs("held_rst");
        rst = 1'b0;
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
